// File: rtl/rf_port_arbiter_pkg.sv
// Shared types and constants for the register-file port arbiter.
package rf_pkg;

  localparam int REG_W      = 3;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter (packed per-requester fields).
interface rf_port_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [REG_W*NUM_REQ-1:0]  req_regA;
  logic [REG_W*NUM_REQ-1:0]  req_regB;
  logic [REG_W*NUM_REQ-1:0]  req_regW;
  logic [DATA_W*NUM_REQ-1:0] req_dataW;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_dataA;
  logic [DATA_W-1:0]         rsp_dataB;

  modport master (
    output req_valid, req_write, req_lock, req_regA, req_regB, req_regW, req_dataW,
    input  req_ready, rsp_valid, rsp_dataA, rsp_dataB
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_regA, req_regB, req_regW, req_dataW,
    output req_ready, rsp_valid, rsp_dataA, rsp_dataB
  );
endinterface

// File: rtl/rf_port_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin pick, searching upward from ptr with wrap-around.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares one RF read port and one write port among NUM_REQ requesters.
// Define RF_BYPASS_EN to forward same-cycle write data into the read response.
module rf_port_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  rf_port_arbiter_if.slave  bus,
  output logic              RFwrite,
  output logic [REG_W-1:0]  regA,
  output logic [REG_W-1:0]  regB,
  output logic [REG_W-1:0]  regW,
  output logic [DATA_W-1:0] dataW,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state_reg;
  logic [IW-1:0]      owner_reg;
  logic [IW-1:0]      rd_ptr_reg;
  logic [IW-1:0]      wr_ptr_reg;
  logic [NUM_REQ-1:0] rsp_pend_reg;
  logic               run_reg;

  logic [NUM_REQ-1:0] rd_req, wr_req, rd_grant, wr_grant;
  logic [IW-1:0]      rd_idx, wr_idx;
  logic               rd_any, wr_any;
  logic               resp_any;

  logic [REG_W-1:0]   rega_arr [NUM_REQ];
  logic [REG_W-1:0]   regb_arr [NUM_REQ];
  logic [REG_W-1:0]   regw_arr [NUM_REQ];
  logic [DATA_W-1:0]  dw_arr   [NUM_REQ];

  // run_reg clears asynchronously with reset, so no grant is issued while reset is high.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic eligible;
      assign eligible     = run_reg && bus.req_valid[gi] &&
                            ((state_reg == ARB) || (owner_reg == IW'(gi)));
      assign rd_req[gi]   = eligible && !bus.req_write[gi];
      assign wr_req[gi]   = eligible &&  bus.req_write[gi];
      assign rega_arr[gi] = bus.req_regA[gi*REG_W +: REG_W];
      assign regb_arr[gi] = bus.req_regB[gi*REG_W +: REG_W];
      assign regw_arr[gi] = bus.req_regW[gi*REG_W +: REG_W];
      assign dw_arr[gi]   = bus.req_dataW[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(.N(NUM_REQ)) u_rd_pick (
    .req   (rd_req),
    .ptr   (rd_ptr_reg),
    .grant (rd_grant),
    .idx   (rd_idx),
    .any   (rd_any)
  );

  rr_pick #(.N(NUM_REQ)) u_wr_pick (
    .req   (wr_req),
    .ptr   (wr_ptr_reg),
    .grant (wr_grant),
    .idx   (wr_idx),
    .any   (wr_any)
  );

  assign bus.req_ready = rd_grant | wr_grant;

  assign regA    = rd_any ? rega_arr[rd_idx] : '0;
  assign regB    = rd_any ? regb_arr[rd_idx] : '0;
  assign RFwrite = wr_any;
  assign regW    = wr_any ? regw_arr[wr_idx] : '0;
  assign dataW   = wr_any ? dw_arr[wr_idx]   : '0;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB;
      owner_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rsp_pend_reg <= '0;
      run_reg      <= 1'b0;
    end else begin
      run_reg      <= 1'b1;
      rsp_pend_reg <= rd_grant;
      if (rd_any) rd_ptr_reg <= IW'(rr_next(int'(rd_idx), NUM_REQ));
      if (wr_any) wr_ptr_reg <= IW'(rr_next(int'(wr_idx), NUM_REQ));
      case (state_reg)
        ARB: begin
          if (rd_any && bus.req_lock[rd_idx]) begin
            state_reg <= LOCKED;
            owner_reg <= rd_idx;
          end
        end
        LOCKED: begin
          if (wr_any && (wr_idx == owner_reg) && !bus.req_lock[wr_idx])
            state_reg <= ARB;
        end
      endcase
    end
  end

  assign resp_any      = |rsp_pend_reg;
  assign bus.rsp_valid = rsp_pend_reg;

`ifdef RF_BYPASS_EN
  logic              byp_a_reg;
  logic              byp_b_reg;
  logic [DATA_W-1:0] byp_data_reg;

  // The RF returns pre-write data on a collision; remember the write to patch the response.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      byp_a_reg    <= 1'b0;
      byp_b_reg    <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_a_reg    <= rd_any && wr_any && (regA == regW);
      byp_b_reg    <= rd_any && wr_any && (regB == regW);
      byp_data_reg <= dataW;
    end
  end

  assign bus.rsp_dataA = !resp_any ? '0 : (byp_a_reg ? byp_data_reg : dataA);
  assign bus.rsp_dataB = !resp_any ? '0 : (byp_b_reg ? byp_data_reg : dataB);
`else
  assign bus.rsp_dataA = resp_any ? dataA : '0;
  assign bus.rsp_dataB = resp_any ? dataB : '0;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed-vector bench for rf_port_arbiter with a registered-read register-file model.
module tb_rf_port_arbiter;
  logic        CLK = 1'b0;
  logic        reset;
  logic        RFwrite;
  logic [2:0]  regA, regB, regW;
  logic [15:0] dataW;
  logic [15:0] rf_dA = '0;
  logic [15:0] rf_dB = '0;
  logic [15:0] rf_mem [8] = '{16'h0000, 16'h0011, 16'h0000, 16'h0000,
                              16'h0000, 16'h0001, 16'h0000, 16'h0000};
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  rf_port_arbiter_if #(.NUM_REQ(3), .DATA_W(16)) bus ();

  rf_port_arbiter #(.NUM_REQ(3), .DATA_W(16)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .bus     (bus),
    .RFwrite (RFwrite),
    .regA    (regA),
    .regB    (regB),
    .regW    (regW),
    .dataW   (dataW),
    .dataA   (rf_dA),
    .dataB   (rf_dB)
  );

  // Register file: write and registered read on the same edge, read returns old data.
  always @(posedge CLK) begin
    if (RFwrite) rf_mem[regW] <= dataW;
    rf_dA <= rf_mem[regA];
    rf_dB <= rf_mem[regB];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock  = '0;
    bus.req_regA  = '0;
    bus.req_regB  = '0;
    bus.req_regW  = '0;
    bus.req_dataW = '0;
  endtask

  task automatic rd(input int i, input logic [2:0] a, input logic [2:0] b, input logic lk);
    bus.req_valid[i]        = 1'b1;
    bus.req_write[i]        = 1'b0;
    bus.req_lock[i]         = lk;
    bus.req_regA[i*3 +: 3]  = a;
    bus.req_regB[i*3 +: 3]  = b;
  endtask

  task automatic wr(input int i, input logic [2:0] w, input logic [15:0] d, input logic lk);
    bus.req_valid[i]         = 1'b1;
    bus.req_write[i]         = 1'b1;
    bus.req_lock[i]          = lk;
    bus.req_regW[i*3 +: 3]   = w;
    bus.req_dataW[i*16 +: 16] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_byp;
`ifdef RF_BYPASS_EN
    exp_byp = 16'hBEEF;
`else
    exp_byp = 16'h0001;
`endif
    // Reset state, with a read pending that must not be granted
    reset = 1'b1;
    clr();
    rd(0, 3'd2, 3'd0, 1'b0);
    @(negedge CLK);
    check("rst_ready",   32'(bus.req_ready), 32'h0);
    check("rst_rsp",     32'(bus.rsp_valid), 32'h0);
    check("rst_rfwrite", 32'(RFwrite),       32'h0);
    check("rst_dataA",   32'(bus.rsp_dataA), 32'h0);
    check("rst_dataB",   32'(bus.rsp_dataB), 32'h0);
    tick(); reset = 1'b0; clr();
    tick();

    // Reset during an in-flight read drops the response
    rd(0, 3'd2, 3'd0, 1'b0);
    @(negedge CLK); check("A_grant", 32'(bus.req_ready), 32'h1);
    tick(); reset = 1'b1;
    @(negedge CLK); check("A_rsp_in_rst", 32'(bus.rsp_valid), 32'h0);
    tick(); reset = 1'b0; clr();
    tick();
    @(negedge CLK); check("A_rsp_after", 32'(bus.rsp_valid), 32'h0);
    tick();

    // Three readers: rotation must start at 0 (read pointer cleared by reset)
    rd(0, 3'd1, 3'd2, 1'b0); rd(1, 3'd3, 3'd4, 1'b0); rd(2, 3'd5, 3'd6, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check($sformatf("B_grant%0d", k), 32'(bus.req_ready), 32'(1 << (k % 3)));
      if (k > 0) check($sformatf("B_rsp%0d", k), 32'(bus.rsp_valid), 32'(1 << ((k - 1) % 3)));
      if (k == 1) check("B_rsp_dataA", 32'(bus.rsp_dataA), 32'h0011);
      tick();
    end
    clr();
    @(negedge CLK); check("B_rsp_last", 32'(bus.rsp_valid), 32'h4);
    tick();

    // Two writers (write pointer 0 -> req0 first), then req1 reads back r3/r7
    wr(0, 3'd3, 16'h00A5, 1'b0); wr(1, 3'd7, 16'h0777, 1'b0);
    @(negedge CLK);
    check("C_ready0", 32'(bus.req_ready), 32'h1);
    check("C_rfw0",   32'(RFwrite),       32'h1);
    check("C_regW0",  32'(regW),          32'h3);
    check("C_dataW0", 32'(dataW),         32'h00A5);
    tick(); bus.req_valid[0] = 1'b0;
    @(negedge CLK);
    check("C_ready1", 32'(bus.req_ready), 32'h2);
    check("C_regW1",  32'(regW),          32'h7);
    tick(); clr(); rd(1, 3'd3, 3'd7, 1'b0);
    @(negedge CLK);
    check("C_rd_ready", 32'(bus.req_ready), 32'h2);
    check("C_regA",     32'(regA),          32'h3);
    tick(); clr();
    @(negedge CLK);
    check("C_rsp",     32'(bus.rsp_valid), 32'h2);
    check("C_dataA",   32'(bus.rsp_dataA), 32'h00A5);
    check("C_dataB",   32'(bus.rsp_dataB), 32'h0777);
    check("C_rfw_off", 32'(RFwrite),       32'h0);
    tick();

    // Locked read-modify-write by req1
    rd(1, 3'd4, 3'd0, 1'b1);
    @(negedge CLK); check("D_lock_grant", 32'(bus.req_ready), 32'h2);
    tick(); clr(); rd(0, 3'd0, 3'd0, 1'b0); rd(2, 3'd2, 3'd0, 1'b0);
    @(negedge CLK);
    check("D_blocked1", 32'(bus.req_ready), 32'h0);
    check("D_rsp",      32'(bus.rsp_valid), 32'h2);
    tick();
    @(negedge CLK); check("D_blocked2", 32'(bus.req_ready), 32'h0);
    tick(); wr(1, 3'd4, 16'h1234, 1'b0);
    @(negedge CLK);
    check("D_unlock_ready", 32'(bus.req_ready), 32'h2);
    check("D_unlock_rfw",   32'(RFwrite),       32'h1);
    check("D_unlock_dataW", 32'(dataW),         32'h1234);
    tick(); bus.req_valid[1] = 1'b0;
    @(negedge CLK); check("D_next_req2", 32'(bus.req_ready), 32'h4);
    tick(); clr();
    @(negedge CLK); check("D_rsp2", 32'(bus.rsp_valid), 32'h4);
    tick();

    // Same-cycle write r5 / read r5 collision
    wr(0, 3'd5, 16'hBEEF, 1'b0); rd(2, 3'd5, 3'd6, 1'b0);
    @(negedge CLK); check("E_ready", 32'(bus.req_ready), 32'h5);
    tick(); clr();
    @(negedge CLK);
    check("E_rsp",   32'(bus.rsp_valid), 32'h4);
    check("E_dataA", 32'(bus.rsp_dataA), 32'(exp_byp));
    check("E_dataB", 32'(bus.rsp_dataB), 32'h0);
    tick(); rd(2, 3'd5, 3'd5, 1'b0);
    @(negedge CLK); check("E_reread_ready", 32'(bus.req_ready), 32'h4);
    tick(); clr();
    @(negedge CLK); check("E_reread_dataA", 32'(bus.rsp_dataA), 32'hBEEF);
    tick();

    // Independent read and write grants in the same cycle
    rd(0, 3'd1, 3'd0, 1'b0); wr(1, 3'd6, 16'h0606, 1'b0);
    @(negedge CLK);
    check("F_ready", 32'(bus.req_ready), 32'h3);
    check("F_rfw",   32'(RFwrite),       32'h1);
    check("F_regA",  32'(regA),          32'h1);
    check("F_regW",  32'(regW),          32'h6);
    tick(); clr();
    @(negedge CLK);
    check("F_rsp",   32'(bus.rsp_valid), 32'h1);
    check("F_dataA", 32'(bus.rsp_dataA), 32'h0011);
    tick();

    // Single requester streams without bubbles
    rd(2, 3'd2, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("G_ready%0d", k), 32'(bus.req_ready), 32'h4);
      if (k > 0) check($sformatf("G_rsp%0d", k), 32'(bus.rsp_valid), 32'h4);
      tick();
    end
    clr();
    @(negedge CLK); check("G_rsp_last", 32'(bus.rsp_valid), 32'h4);
    tick();
    @(negedge CLK);
    check("G_idle_rsp", 32'(bus.rsp_valid), 32'h0);
    check("G_idle_rfw", 32'(RFwrite),       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_port_arbiter.md
RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter DATA_W, default 16, register data width.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request pending.
REQ-006 SHALL have port req_write  input  NUM_REQ  per-requester op: 1 = write regW, 0 = read regA/regB.
REQ-007 SHALL have port req_lock  input  NUM_REQ  per-requester lock hint for read-modify-write.
REQ-008 SHALL have port req_regA, req_regB, req_regW  input  3*NUM_REQ each  packed register numbers.
REQ-009 SHALL have port req_dataW  input  DATA_W*NUM_REQ  packed write data.
REQ-010 SHALL have port req_ready  output  NUM_REQ  grant; transfer when req_valid & req_ready at an edge.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-hot read response strobe.
REQ-012 SHALL have port rsp_dataA, rsp_dataB  output  DATA_W each  shared read response data.
REQ-013 SHALL have port RFwrite, regA, regB, regW, dataW  output  1/3/3/3/DATA_W  register-file drive.
REQ-014 SHALL have port dataA, dataB  input  DATA_W each  register-file read data, registered inside the register file (1-cycle).

Function
REQ-015 SHALL arbitrate read and write ports independently each cycle: at most one read grant and one write grant per cycle, to different or same requesters.
REQ-016 SHALL use a separate round-robin pointer per port; pointer advances to (winner+1) mod NUM_REQ only on a completed transfer.
REQ-017 SHALL drive regA/regB from the read winner and RFwrite/regW/dataW from the write winner combinationally; RFwrite = 1 only on a completed write transfer.
REQ-018 SHALL assert rsp_valid[i] exactly one cycle after requester i's read transfer, with rsp_dataA/rsp_dataB = register-file dataA/dataB in that cycle.
REQ-019 SHALL implement FSM states ARB and LOCKED; ARB -> LOCKED on a read transfer with req_lock = 1 (owner recorded); LOCKED -> ARB on owner's write transfer with req_lock = 0.
REQ-020 SHALL, in LOCKED, grant both ports only to the owner; all other req_ready = 0.
REQ-021 SHALL, on same-cycle read and write to the same register, return pre-write data unless RF_BYPASS_EN is defined.
REQ-022 SHALL keep req_ready de-asserted for requesters with req_valid = 0; rsp_valid and RFwrite SHALL be 0 when no transfer.
REQ-023 SHALL, with a single requester requesting, grant it every cycle (no bubbles).

Reset
REQ-024 SHALL on reset force FSM to ARB, both pointers to 0, rsp_valid to 0, RFwrite to 0, rsp_dataA/rsp_dataB to 0.
REQ-025 SHALL drop any in-flight read response when reset asserts mid-operation; no rsp_valid after release for pre-reset reads.
REQ-026 SHALL not grant in the cycle reset is high.

Configuration
REQ-027 SHALL, when RF_BYPASS_EN is defined, register regA/regB-vs-regW match flags and dataW at the transfer edge and substitute dataW into rsp_dataA/rsp_dataB in the response cycle.
REQ-028 SHALL, without RF_BYPASS_EN, pass dataA/dataB unmodified (old value on same-cycle collision).

Structure
REQ-029 SHALL place FSM state encoding, register-number width (3) and default DATA_W in shared package rf_pkg.
REQ-030 SHALL implement round-robin selection in one sub-module rr_pick, instantiated twice (read, write).

Verification
REQ-031 Reset mid-read: read r2 granted, reset next cycle -> rsp_valid stays 0, pointers 0.
REQ-032 Req0 writes r3=0x00A5, then req1 reads r3 -> rsp_valid[1] one cycle after grant, rsp_dataA = 0x00A5.
REQ-033 All three requesters hold read requests for 6 cycles -> grants order 0,1,2,0,1,2.
REQ-034 Req1 read r4 with lock, req0 and req2 requesting -> only req1 granted until req1 writes r4=0x1234 lock=0; then req2 granted next.
REQ-035 Same cycle req0 writes r5=0xBEEF (old 0x0001), req2 reads r5 -> rsp_dataA = 0xBEEF with RF_BYPASS_EN, 0x0001 without.
REQ-036 Req0 read r1 and req1 write r6 same cycle -> both req_ready high, RFwrite = 1, rsp_valid[0] next cycle.
